// File: rtl/rftfa_serial_ctrl_pkg.sv
// rftfa_serial_ctrl_pkg
// Shared definitions for RFTFA-based serial controllers: FSM state
// encodings and the bit positions of the RFTFA cell's 4-bit in/out buses.
package rftfa_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // RFTFA cell bus bit positions (input side / output side)
  localparam int FA_A    = 0;
  localparam int FA_B    = 1;
  localparam int FA_CIN  = 2;
  localparam int FA_SUM  = 2;
  localparam int FA_COUT = 3;

endpackage

// File: rtl/rftfa_serial_ctrl_parity4_chk.sv
// parity4_chk
// Combinational parity comparator for a 4-in/4-out parity-preserving
// reversible cell. A healthy cell keeps XOR(inputs) == XOR(outputs).
// Ports:
//   fa_in_i   [3:0]  vector driven into the cell
//   fa_out_i  [3:0]  vector returned by the cell
//   par_err_o        1 when the two parities differ
module parity4_chk (
  input  logic [3:0] fa_in_i,
  input  logic [3:0] fa_out_i,
  output logic       par_err_o
);

  assign par_err_o = (^fa_in_i) ^ (^fa_out_i);

endmodule

// File: rtl/rftfa_serial_ctrl.sv
// rftfa_serial_ctrl
// Bit-serial WIDTH-bit adder that drives one external RFTFA cell, one bit
// per clock, LSB first, and aborts with a sticky fault flag when the cell
// breaks its parity-preserving property.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start_i           request, only honoured in IDLE
//   a_i, b_i, cin_i   operands, captured when start is accepted
//   busy_o            high in RUN and DONE
//   done_o            one-cycle completion pulse
//   sum_o, cout_o     result of the last clean operation
//   fault_o           parity violation in the last operation
//   fa_in_o/fa_out_i  connection to the RFTFA cell
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start; cell input forced to zero
// RUN     | one operand bit per clock through the RFTFA cell
// DONE    | done pulse for one cycle, then back to IDLE
module rftfa_serial_ctrl
  import rftfa_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             fault_o,
  output logic [3:0]       fa_in_o,
  input  logic [3:0]       fa_out_i
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic [WIDTH-1:0] r_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             fault_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       fa_in_d;
  logic             par_err;

  always_comb begin
    fa_in_d = 4'b0000;
    if (state_q == ST_RUN) begin
      fa_in_d[FA_A]   = a_sh_q[0];
      fa_in_d[FA_B]   = b_sh_q[0];
      fa_in_d[FA_CIN] = carry_q;
    end
  end

  // Result fills from the MSB end so that after WIDTH shifts bit 0 sits at LSB.
  assign r_sh_d = {fa_out_i[FA_SUM], r_sh_q[WIDTH-1:1]};

  parity4_chk u_parity4_chk (
    .fa_in_i  (fa_in_d),
    .fa_out_i (fa_out_i),
    .par_err_o(par_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (par_err) begin
            // Partial result is dropped; sum/cout keep the last clean answer.
            fault_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            r_sh_q  <= r_sh_d;
            carry_q <= fa_out_i[FA_COUT];
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              sum_q   <= r_sh_d;
              cout_q  <= fa_out_i[FA_COUT];
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign fault_o = fault_q;
  assign fa_in_o = fa_in_d;

endmodule

// File: tb/tb_rftfa_serial_ctrl.sv
// tb_rftfa_serial_ctrl
// Scoreboard bench: an 8-bit and a 4-bit controller, each wired to a
// behavioural RFTFA cell. Issued operations push the expected result
// (plain integer addition, or the held result on an injected fault) and
// the completion cycle; monitors pop and compare on every done pulse.
module tb_rftfa_serial_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        fault;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int n_chk;
  int n_fail;

  exp_t q8[$];
  exp_t q4[$];
  logic [7:0] last_sum8;
  logic       last_cout8;
  logic       prev8, prev4;

  logic       start8, cin8, busy8, done8, cout8, fault8, inj8;
  logic [7:0] a8, b8, sum8;
  logic [3:0] fa_in8, fa_out8;

  logic       start4, cin4, busy4, done4, cout4, fault4;
  logic [3:0] a4, b4, sum4;
  logic [3:0] fa_in4, fa_out4;

  // Parity-preserving full adder: out = {cout, sum, a^cout, a}
  function automatic logic [3:0] rftfa(input logic [3:0] i);
    logic a, b, c, s, co;
    a  = i[0];
    b  = i[1];
    c  = i[2];
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s, a ^ co, a};
  endfunction

  assign fa_out8 = rftfa(fa_in8) ^ {3'b000, inj8};
  assign fa_out4 = rftfa(fa_in4);

  rftfa_serial_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .fault_o(fault8),
    .fa_in_o(fa_in8), .fa_out_i(fa_out8)
  );

  rftfa_serial_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
    .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4), .fault_o(fault4),
    .fa_in_o(fa_in4), .fa_out_i(fa_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev8 = 1'b0;
    else begin
      if (prev8) begin
        chk("done8_width", 32'(done8), 32'd0);
        chk("busy8_after_done", 32'(busy8), 32'd0);
      end
      if (done8) begin
        if (q8.size() == 0) begin
          chk("done8_unexpected", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          chk("sum8", 32'(sum8), e.sum);
          chk("cout8", 32'(cout8), 32'(e.cout));
          chk("fault8", 32'(fault8), 32'(e.fault));
          chk("done8_cycle", cyc, e.cyc);
        end
      end
      prev8 = done8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev4 = 1'b0;
    else begin
      if (prev4) begin
        chk("done4_width", 32'(done4), 32'd0);
        chk("busy4_after_done", 32'(busy4), 32'd0);
      end
      if (done4) begin
        if (q4.size() == 0) begin
          chk("done4_unexpected", 32'(done4), 32'd0);
        end else begin
          e = q4.pop_front();
          chk("sum4", 32'(sum4), e.sum);
          chk("cout4", 32'(cout4), 32'(e.cout));
          chk("fault4", 32'(fault4), 32'(e.fault));
          chk("done4_cycle", cyc, e.cyc);
        end
      end
      prev4 = done4;
    end
  end

  // Call between clock edges with the 8-bit DUT idle. fk < 0: clean run,
  // otherwise fa_out[0] is inverted while bit fk is presented.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input int fk);
    exp_t e;
    logic [8:0] full;
    int unsigned t0;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    t0 = cyc;
    chk("busy8_on_accept", 32'(busy8), 32'd1);
    chk("fault8_clear_on_accept", 32'(fault8), 32'd0);
    if (fk < 0) begin
      full = 9'(a) + 9'(b) + 9'(c);
      last_sum8  = full[7:0];
      last_cout8 = full[8];
      e.sum = 32'(last_sum8); e.cout = last_cout8; e.fault = 1'b0; e.cyc = t0 + 8;
      q8.push_back(e);
    end else begin
      e.sum = 32'(last_sum8); e.cout = last_cout8; e.fault = 1'b1;
      e.cyc = t0 + 1 + fk;
      q8.push_back(e);
      repeat (fk) @(posedge clk);
      #1 inj8 = 1'b1;
      @(posedge clk);
      #1 inj8 = 1'b0;
    end
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
    exp_t e;
    logic [4:0] full;
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    full = 5'(a) + 5'(b) + 5'(c);
    e.sum = 32'(full[3:0]); e.cout = full[4]; e.fault = 1'b0; e.cyc = cyc + 4;
    q4.push_back(e);
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy8) break;
    end
    chk("wait_idle8", 32'(busy8), 32'd0);
  endtask

  task automatic wait_idle4();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy4) break;
    end
    chk("wait_idle4", 32'(busy4), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_chk = 0; n_fail = 0;
    last_sum8 = '0; last_cout8 = 1'b0;
    prev8 = 1'b0; prev4 = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; inj8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    rst_n = 1'b0;
    #23;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_fault", 32'(fault8), 32'd0);
    chk("rst_fa_in", 32'(fa_in8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: clean, fault with held result, clearing, carry cases
    issue8(8'h03, 8'h05, 1'b0, -1); wait_idle8();
    issue8(8'h12, 8'h34, 1'b0, 3);  wait_idle8();
    chk("fault8_sticky", 32'(fault8), 32'd1);
    issue8(8'hFF, 8'h01, 1'b0, -1); wait_idle8();
    chk("fault8_cleared", 32'(fault8), 32'd0);
    issue8(8'h7F, 8'h80, 1'b1, -1); wait_idle8();

    // start pulsed during RUN and in the done cycle must be ignored
    issue8(8'h21, 8'h42, 1'b0, -1);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1'b1; break; end
    end
    chk("glitch_done_seen", 32'(seen), 32'd1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_no_restart", 32'(busy8), 32'd0);
    chk("glitch_sum_kept", 32'(sum8), 32'h63);

    // Reset while bit 5 is in flight
    issue8(8'h5A, 8'h3C, 1'b0, -1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_cout", 32'(cout8), 32'd0);
    chk("midrst_fault", 32'(fault8), 32'd0);
    chk("midrst_fa_in", 32'(fa_in8), 32'd0);
    void'(q8.pop_back());
    last_sum8 = '0; last_cout8 = 1'b0;
    #4 rst_n = 1'b1;
    @(negedge clk);
    issue8(8'h10, 8'h20, 1'b0, -1); wait_idle8();

    // Randomized, back-to-back, with occasional injected faults
    for (int n = 0; n < 80; n++) begin
      int fk;
      fk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      issue8(8'($urandom), 8'($urandom), 1'($urandom), fk);
      wait_idle8();
    end

    // Exhaustive sweep on the 4-bit instance
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          issue4(4'(a), 4'(b), 1'(c));
          wait_idle4();
        end

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
